// File: rtl/dbg_pkg.sv
// Shared types for the debug step controller: FSM state encoding and mode codes.
package dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_BURST  = 2'd2;
    localparam logic [1:0] MODE_RUN    = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, and a one-cycle
// press strobe on the accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic sysclk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int            CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle that agrees with the stable level restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == TC) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (reset_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = sync2_q & ~stable_q & (cnt_q == TC);

endmodule

// File: rtl/dbg_step_ctrl.sv
// Debug step controller: debounced button launches single/burst/free-run pulse
// trains on the CPU pulse_* inputs. Event counters exist only with DBG_EVT_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a press; pulse held at 0
// FIRE  | pulse = latched ch_sel for this cycle
// WAIT  | gap cycles between pulses
module dbg_step_ctrl
    import dbg_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int BURST_W      = 8,
    parameter int GAP_W        = 16,
    parameter int CNT_W        = 16
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               btn,
    input  logic [1:0]         mode,
    input  logic [NUM_CH-1:0]  ch_sel,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [GAP_W-1:0]   gap,
    output logic [NUM_CH-1:0]  pulse,
    output logic               busy,
    input  logic               interrupt,
    input  logic               read_acc,
    input  logic               write_acc,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   cnt_int,
    output logic [CNT_W-1:0]   cnt_rd,
    output logic [CNT_W-1:0]   cnt_wr
);

    logic press;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
        .sysclk_i(sysclk),
        .reset_i (reset),
        .btn_i   (btn),
        .press_o (press)
    );

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [NUM_CH-1:0]  ch_q, ch_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_CH-1:0]  pulse_q, pulse_d;
    logic               abort;

    // OFF always aborts; RUN additionally stops on a press or any mode change.
    assign abort = (mode == MODE_OFF) ||
                   ((mode_q == MODE_RUN) && (press || (mode != MODE_RUN)));

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        ch_d      = ch_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        pulse_d   = '0;
        case (state_q)
            IDLE: begin
                if (press && (mode != MODE_OFF) &&
                    !((mode == MODE_BURST) && (burst_len == '0))) begin
                    state_d = FIRE;
                    mode_d  = mode;
                    ch_d    = ch_sel;
                    rem_d   = burst_len;
                    gap_d   = gap;
                    pulse_d = ch_sel;
                end
            end
            FIRE: begin
                rem_d = rem_q - 1'b1;
                if (abort || (mode_q == MODE_SINGLE) ||
                    ((mode_q == MODE_BURST) && (rem_q == BURST_W'(1)))) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    pulse_d = ch_q;
                end else begin
                    state_d   = WAIT;
                    gap_cnt_d = gap_q;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = FIRE;
                    pulse_d = ch_q;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= MODE_OFF;
            ch_q      <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            pulse_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            ch_q      <= ch_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = (state_q != IDLE);

`ifdef DBG_EVT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             int_prev_q;
    logic [CNT_W-1:0] cnt_int_q, cnt_rd_q, cnt_wr_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            int_prev_q <= 1'b0;
            cnt_int_q  <= '0;
            cnt_rd_q   <= '0;
            cnt_wr_q   <= '0;
        end else begin
            int_prev_q <= interrupt;
            if (cnt_clr) begin
                cnt_int_q <= '0;
                cnt_rd_q  <= '0;
                cnt_wr_q  <= '0;
            end else begin
                if (interrupt && !int_prev_q && (cnt_int_q != CNT_MAX)) cnt_int_q <= cnt_int_q + 1'b1;
                if (read_acc && (cnt_rd_q != CNT_MAX))  cnt_rd_q <= cnt_rd_q + 1'b1;
                if (write_acc && (cnt_wr_q != CNT_MAX)) cnt_wr_q <= cnt_wr_q + 1'b1;
            end
        end
    end

    assign cnt_int = cnt_int_q;
    assign cnt_rd  = cnt_rd_q;
    assign cnt_wr  = cnt_wr_q;
`else
    logic unused_evt;
    assign unused_evt = ^{interrupt, read_acc, write_acc, cnt_clr};
    assign cnt_int    = '0;
    assign cnt_rd     = '0;
    assign cnt_wr     = '0;
`endif

endmodule

// File: doc/dbg_step_ctrl.md
# dbg_step_ctrl

Parametrised debug step controller that drives the CPU's `pulse_*` stepping inputs, which the top-level test wrapper currently ties to 0. It debounces a board button and emits per-channel one-cycle pulses in single-step, burst or free-run modes. It optionally counts CPU `interrupt`/`read_acc`/`write_acc` activity. It sits between board I/O and the CPU core at top level.

## Interface
- `NUM_CH`, 4, number of pulse channels (inst, alu, mem, reg by default)
- `DEBOUNCE_CYC`, 50000, consecutive stable cycles required to accept a button level change (≥2)
- `BURST_W`, 8, width of `burst_len`
- `GAP_W`, 16, width of `gap`
- `CNT_W`, 16, width of each event counter
- `sysclk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `btn`  in  1  raw asynchronous button, active-high
- `mode`  in  2  0 OFF, 1 SINGLE, 2 BURST, 3 RUN
- `ch_sel`  in  NUM_CH  mask of channels that pulse
- `burst_len`  in  BURST_W  pulses per press in BURST mode
- `gap`  in  GAP_W  low cycles between consecutive pulses
- `pulse`  out  NUM_CH  registered step pulses, one cycle wide each
- `busy`  out  1  high whenever FSM is not IDLE
- `interrupt`, `read_acc`, `write_acc`  in  1 each  CPU event inputs
- `cnt_clr`  in  1  synchronous clear of event counters
- `cnt_int`, `cnt_rd`, `cnt_wr`  out  CNT_W each  event counts

## Operation
- `btn` passes a 2-FF synchroniser, then the debouncer. The stable level flips only after the synchronised value differs from it for DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts the count. `press` is a one-cycle strobe on the stable 0→1 edge.
- FSM states: IDLE, FIRE, WAIT.
- Configuration latch:
  - `mode`, `ch_sel`, `burst_len` and `gap` are latched on the `press` that leaves IDLE.
  - Later changes are ignored, except `mode`==OFF, which forces IDLE on the next cycle with `pulse`=0.
- IDLE + `press`:
  - OFF: ignored.
  - SINGLE, BURST with `burst_len`≠0, or RUN: → FIRE.
  - BURST with `burst_len`=0: ignored.
- FIRE: `pulse`=latched `ch_sel` for exactly one cycle; burst counter decrements.
  - SINGLE, or BURST with remaining=0: → IDLE.
  - Latched `gap`=0: stay in FIRE (back-to-back pulses).
  - Otherwise: → WAIT.
- WAIT: `pulse`=0. The gap counter counts latched `gap` cycles, then → FIRE.
- RUN loops FIRE/WAIT indefinitely. A `press`, or `mode`≠3 while running, → IDLE next cycle; no further pulse is issued.
- A `press` during SINGLE or BURST activity is dropped, not queued.
- `ch_sel`=0 still walks the FSM (`busy` asserted) but every pulse is all-zero.

## Timing
- Reset values: `pulse`=0, `busy`=0, state IDLE, debouncer stable level 0, debounce/gap/burst counters 0, event counters 0, synchroniser FFs 0.
- `press` high in cycle t → `pulse` high in cycle t+1 (registered output).
- Pulse period = latched `gap`+1 cycles. A BURST of N pulses spans N+(N−1)·gap cycles.
- `busy` rises in the same cycle as the first pulse and falls the cycle after the last pulse.
- Reset asserted mid-burst: `pulse`=0 from the next edge and the sequence is abandoned; no resume.
- Button latency from raw edge to `press` = 2 sync cycles + DEBOUNCE_CYC cycles.

## Configuration
- `DBG_EVT_CNT_EN` defined:
  - `cnt_int` counts rising edges of `interrupt`.
  - `cnt_rd` counts cycles where `read_acc`=1; `cnt_wr` counts cycles where `write_acc`=1.
  - All three saturate at 2^CNT_W−1.
  - `cnt_clr` zeroes all three; when `cnt_clr` coincides with an event, the clear wins.
- `DBG_EVT_CNT_EN` undefined: ports remain, `cnt_*` are constant 0, and no counter flops are generated.

## Structure
- Package `dbg_pkg`: FSM state enum (IDLE, FIRE, WAIT) and mode constants (MODE_OFF/SINGLE/BURST/RUN).
- Sub-module `btn_debounce` (synchroniser, debounce counter, `press` strobe; parameter DEBOUNCE_CYC).

## Test plan
Bench uses DEBOUNCE_CYC=4, NUM_CH=4.
- SINGLE, `ch_sel`=4'b0101, one clean press → exactly one cycle `pulse`=4'b0101, `busy` high 1 cycle.
- BURST, `burst_len`=3, `gap`=2 → pulses at relative cycles 0,3,6; then `busy` low; `burst_len`=0 press → no pulse, `busy` stays 0.
- Bouncing `btn` (toggle every 2 cycles for 20 cycles, then held high) → exactly one `press`, one pulse.
- RUN, `gap`=0 → `pulse` high every cycle; second press → `pulse`=0 from following cycle; `mode` switched to OFF mid-run → IDLE next cycle.
- Reset asserted during BURST `burst_len`=10 after 4 pulses → no further pulses, `busy`=0 after reset edge.
- With `DBG_EVT_CNT_EN`, CNT_W=4:
  - 20 `read_acc` cycles → `cnt_rd`=15 (saturated).
  - 3 `interrupt` edges → `cnt_int`=3.
  - `cnt_clr` concurrent with `write_acc` → `cnt_wr`=0.
